// File: rtl/registers_controller_pkg.sv
// Shared constants for the multi-channel register controller:
// register word offsets, CTRL bit positions, reset value and ID word.
package registers_controller_pkg;

  localparam logic [31:0] ID_VALUE = 32'h524D_4301;

  localparam int unsigned OFF_ID      = 'h00;
  localparam int unsigned OFF_CTRL    = 'h01;
  localparam int unsigned OFF_CLEAR   = 'h02;
  localparam int unsigned OFF_STATUS  = 'h03;
  localparam int unsigned OFF_IRQ_EN  = 'h04;
  localparam int unsigned OFF_COUNT   = 'h10;
  localparam int unsigned OFF_SCRATCH = 'h20;

  localparam int unsigned CTRL_W   = 3;
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_SAT = 1;
  localparam int unsigned CTRL_COR = 2;

  // Counting enabled, wrap on overflow, no clear-on-read.
  localparam logic [CTRL_W-1:0] CTRL_RESET = 3'b001;

endpackage

// File: rtl/registers_controller_mc_msg_counter.sv
// Per-channel message counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one message (already gated by the enable)
//   clr        : explicit clear; beats everything else
//   rd_clr     : clear-on-read; a coincident inc leaves the counter at 1
//   sat        : 1 = hold at max on overflow, 0 = wrap to zero
//   count      : current count
//   ovf_pulse  : one-cycle pulse, registered, following an overflowing increment
module msg_counter #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  input  logic               rd_clr,
  input  logic               sat,
  output logic [COUNT_W-1:0] count,
  output logic               ovf_pulse
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic at_max_c;
  assign at_max_c = (count == COUNT_MAX);

  // Counter update with clear > clear-on-read > increment priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= inc && !clr && !rd_clr && at_max_c;
      if (clr) begin
        count <= '0;
      end else if (rd_clr) begin
        count <= inc ? COUNT_W'(1) : '0;
      end else if (inc) begin
        if (at_max_c) begin
          count <= sat ? COUNT_MAX : '0;
        end else begin
          count <= count + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/registers_controller_mc.sv
// Multi-channel Avalon-MM register slave counting msg_enter pulses per channel.
//   clk, rst_n        : clock, async active-low reset
//   msg_enter         : one-cycle message pulse per channel
//   reg_address       : word address (decoded relative to ADDR_BASE)
//   reg_read/write    : bus requests, accepted while reg_waitrequest is low
//   reg_writedata     : write data
//   reg_readdata      : read data, qualified by reg_readdatavalid
//   reg_readdatavalid : one-cycle strobe RD_LATENCY cycles after read accept
//   reg_waitrequest   : high in reset and for the first edge after it
//   irq               : registered OR of STATUS & IRQ_EN
module registers_controller_mc
  import registers_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned N_SCRATCH  = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   msg_enter,
  input  logic [ADDR_W-1:0] reg_address,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] reg_writedata,
  output logic [DATA_W-1:0] reg_readdata,
  output logic              reg_readdatavalid,
  output logic              reg_waitrequest,
  output logic              irq
);

  localparam int unsigned SCR_DEPTH = (N_SCRATCH == 0) ? 1 : N_SCRATCH;

  logic [CTRL_W-1:0]  ctrl;
  logic [N_CH-1:0]    status;
  logic [N_CH-1:0]    irq_en;
  logic [N_CH-1:0]    ovf;
  logic [N_CH-1:0]    inc_c;
  logic [N_CH-1:0]    clr_c;
  logic [N_CH-1:0]    rd_clr_c;
  logic [N_CH-1:0]    w1c_c;
  logic [COUNT_W-1:0] count   [N_CH];
  logic [DATA_W-1:0]  scratch [SCR_DEPTH];

  logic [ADDR_W-1:0]  off_c;
  logic               below_c;
  logic               rd_acc_c;
  logic               wr_acc_c;
  logic               sel_ctrl_c;
  logic               sel_clear_c;
  logic               sel_status_c;
  logic               sel_irq_en_c;
  logic [DATA_W-1:0]  rd_data_c;

  logic [DATA_W-1:0]     pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld;

  // Address decode relative to the base; below-base addresses hit nothing.
  assign below_c      = (reg_address < ADDR_W'(ADDR_BASE));
  assign off_c        = reg_address - ADDR_W'(ADDR_BASE);
  assign sel_ctrl_c   = !below_c && (off_c == ADDR_W'(OFF_CTRL));
  assign sel_clear_c  = !below_c && (off_c == ADDR_W'(OFF_CLEAR));
  assign sel_status_c = !below_c && (off_c == ADDR_W'(OFF_STATUS));
  assign sel_irq_en_c = !below_c && (off_c == ADDR_W'(OFF_IRQ_EN));

  // A simultaneous read and write performs only the write.
  assign wr_acc_c = reg_write && !reg_waitrequest;
  assign rd_acc_c = reg_read && !reg_write && !reg_waitrequest;

  assign w1c_c = (wr_acc_c && sel_status_c) ? reg_writedata[N_CH-1:0] : '0;

  // One counter per channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign inc_c[i]    = msg_enter[i] && ctrl[CTRL_EN];
    assign clr_c[i]    = wr_acc_c && sel_clear_c && reg_writedata[i];
    assign rd_clr_c[i] = rd_acc_c && ctrl[CTRL_COR] && !below_c &&
                         (off_c == ADDR_W'(OFF_COUNT + i));

    msg_counter #(
      .COUNT_W (COUNT_W)
    ) u_msg_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_c[i]),
      .clr       (clr_c[i]),
      .rd_clr    (rd_clr_c[i]),
      .sat       (ctrl[CTRL_SAT]),
      .count     (count[i]),
      .ovf_pulse (ovf[i])
    );
  end

  // Control/status registers, bus handshake and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl            <= CTRL_RESET;
      status          <= '0;
      irq_en          <= '0;
      irq             <= 1'b0;
      reg_waitrequest <= 1'b1;
    end else begin
      reg_waitrequest <= 1'b0;
      irq             <= |(status & irq_en);
      // New overflow wins over a coincident write-one-to-clear.
      status          <= (status & ~w1c_c) | ovf;
      if (wr_acc_c && sel_ctrl_c) begin
        ctrl <= reg_writedata[CTRL_W-1:0];
      end
      if (wr_acc_c && sel_irq_en_c) begin
        irq_en <= reg_writedata[N_CH-1:0];
      end
    end
  end

  // Scratch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SCR_DEPTH; j++) begin
        scratch[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_SCRATCH; j++) begin
        if (wr_acc_c && !below_c && (off_c == ADDR_W'(OFF_SCRATCH + j))) begin
          scratch[j] <= reg_writedata;
        end
      end
    end
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    rd_data_c = '0;
    if (!below_c) begin
      if (off_c == ADDR_W'(OFF_ID))     rd_data_c = DATA_W'(ID_VALUE);
      if (sel_ctrl_c)                   rd_data_c = DATA_W'(ctrl);
      if (sel_status_c)                 rd_data_c = DATA_W'(status);
      if (sel_irq_en_c)                 rd_data_c = DATA_W'(irq_en);
      for (int i = 0; i < N_CH; i++) begin
        if (off_c == ADDR_W'(OFF_COUNT + i)) rd_data_c = DATA_W'(count[i]);
      end
      for (int j = 0; j < N_SCRATCH; j++) begin
        if (off_c == ADDR_W'(OFF_SCRATCH + j)) rd_data_c = scratch[j];
      end
    end
  end

  // Read return pipeline: data captured at accept, delivered RD_LATENCY cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc_c;
      if (rd_acc_c) begin
        pipe_data[0] <= rd_data_c;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign reg_readdata      = pipe_data[RD_LATENCY-1];
  assign reg_readdatavalid = pipe_vld[RD_LATENCY-1];

endmodule
